// File: rtl/avalon_mm_initiator_pkg.sv
// Shared Avalon-MM constants: response codes and initiator FSM state encoding.
package avalon_mm_initiator_pkg;

    localparam logic [1:0] RespOkay        = 2'b00;
    localparam logic [1:0] RespReserved    = 2'b01;
    localparam logic [1:0] RespSlaveError  = 2'b10;
    localparam logic [1:0] RespDecodeError = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StResp  = 2'd3
    } state_e;

endpackage

// File: rtl/avalon_mm_initiator_if.sv
// Command, response and Avalon-MM bus signals of the initiator, grouped for port connection.
interface avalon_mm_initiator_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_wdata;
    logic [3:0]            cmd_byteenable;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  rsp_timeout;
    logic [7:0]            err_count;

    logic [ADDR_WIDTH-1:0] avl_mm_addr;
    logic                  avl_mm_read;
    logic [31:0]           avl_mm_readdata;
    logic [1:0]            avl_mm_response;
    logic                  avl_mm_write;
    logic [31:0]           avl_mm_writedata;
    logic [3:0]            avl_mm_byteenable;
    logic                  avl_mm_waitrequest;

    // Initiator (DUT) view.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_byteenable,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, err_count,
        input  rsp_ready,
        output avl_mm_addr, avl_mm_read, avl_mm_write, avl_mm_writedata, avl_mm_byteenable,
        input  avl_mm_readdata, avl_mm_response, avl_mm_waitrequest
    );

    // Environment view: command source, response sink and Avalon responder.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_byteenable,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, err_count,
        output rsp_ready,
        input  avl_mm_addr, avl_mm_read, avl_mm_write, avl_mm_writedata, avl_mm_byteenable,
        output avl_mm_readdata, avl_mm_response, avl_mm_waitrequest
    );

endinterface

// File: rtl/avalon_mm_initiator.sv
// Single-outstanding Avalon-MM initiator: registers one command, runs one bus transfer with
// stall timeout, and holds the response until consumed.
module avalon_mm_initiator
    import avalon_mm_initiator_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    avalon_mm_initiator_if.master bus
);

    localparam int unsigned StallW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [StallW-1:0] StallMax   = {StallW{1'b1}};
    localparam logic [StallW-1:0] StallLimit = StallW'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  timeout_q, timeout_d;
    logic [7:0]            err_q, err_d;
    logic [StallW-1:0]     stall_q, stall_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        stall_d   = stall_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                stall_d = '0;
                if (bus.cmd_valid) begin
                    addr_d    = bus.cmd_addr;
                    wdata_d   = bus.cmd_wdata;
                    be_d      = bus.cmd_byteenable;
                    rdata_d   = '0;
                    resp_d    = RespOkay;
                    timeout_d = 1'b0;
                    // A write touching no byte lanes has nothing to do on the bus.
                    if (bus.cmd_write && bus.cmd_byteenable == 4'b0000) begin
                        state_d = StResp;
                    end else if (bus.cmd_write) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead, StWrite: begin
                // Completion is checked first so it wins over a coincident timeout.
                if (!bus.avl_mm_waitrequest) begin
                    rdata_d   = (state_q == StRead) ? bus.avl_mm_readdata : '0;
                    resp_d    = bus.avl_mm_response;
                    timeout_d = 1'b0;
                    state_d   = StResp;
                end else if (TIMEOUT_CYCLES != 0 && stall_q == StallLimit) begin
                    rdata_d   = '0;
                    resp_d    = RespSlaveError;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end else if (stall_q != StallMax) begin
                    stall_d = stall_q + 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StResp && state_d == StResp && (timeout_d || resp_d != RespOkay) &&
            err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            resp_q    <= RespOkay;
            timeout_q <= 1'b0;
            err_q     <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.cmd_ready         = (state_q == StIdle);
    assign bus.rsp_valid         = (state_q == StResp);
    assign bus.rsp_rdata         = rdata_q;
    assign bus.rsp_resp          = resp_q;
    assign bus.rsp_timeout       = timeout_q;
    assign bus.err_count         = err_q;
    assign bus.avl_mm_read       = (state_q == StRead);
    assign bus.avl_mm_write      = (state_q == StWrite);
    assign bus.avl_mm_addr       = addr_q;
    assign bus.avl_mm_writedata  = wdata_q;
    assign bus.avl_mm_byteenable = be_q;

endmodule

// File: tb/tb_avalon_mm_initiator.sv
// Bench for avalon_mm_initiator: directed and random transfers against a transaction-level model.
module tb_avalon_mm_initiator;
    import avalon_mm_initiator_pkg::*;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   err_exp = 0;

    always #5 clk = ~clk;

    avalon_mm_initiator_if #(.ADDR_WIDTH(4)) bus ();

    avalon_mm_initiator #(
        .ADDR_WIDTH    (4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full command/response exchange; expectations come from the transaction rules alone.
    task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int waits, input logic [31:0] rd,
                        input logic [1:0] resp, input int delay);
        bit          skip    = wr && (be == 4'b0000);
        bit          to      = !skip && (waits >= int'(TO));
        int          strobes = skip ? 0 : (to ? int'(TO) : waits + 1);
        logic [31:0] exp_rdata = (!wr && !to) ? rd : 32'h0;
        logic [1:0]  exp_resp  = skip ? RespOkay : (to ? RespSlaveError : resp);
        bit          stall;

        if (to || exp_resp != RespOkay) err_exp = (err_exp == 255) ? 255 : err_exp + 1;

        bus.cmd_valid      = 1'b1;
        bus.cmd_write      = wr;
        bus.cmd_addr       = addr;
        bus.cmd_wdata      = wdata;
        bus.cmd_byteenable = be;
        check("cmd_ready_idle", {31'b0, bus.cmd_ready}, 32'd1);
        check("no_strobe_at_accept", {30'b0, bus.avl_mm_read, bus.avl_mm_write}, 32'd0);
        tick();
        bus.cmd_valid      = 1'b0;
        bus.cmd_write      = $urandom_range(0, 1);
        bus.cmd_addr       = 4'($urandom);
        bus.cmd_wdata      = $urandom;
        bus.cmd_byteenable = 4'($urandom);

        for (int k = 0; k < strobes; k++) begin
            stall = to || (k < waits);
            bus.avl_mm_waitrequest = stall;
            bus.avl_mm_readdata    = stall ? $urandom : rd;
            bus.avl_mm_response    = stall ? 2'($urandom) : resp;
            check("strobe_read", {31'b0, bus.avl_mm_read}, {31'b0, !wr});
            check("strobe_write", {31'b0, bus.avl_mm_write}, {31'b0, wr});
            check("avl_addr", {28'b0, bus.avl_mm_addr}, {28'b0, addr});
            check("avl_be", {28'b0, bus.avl_mm_byteenable}, {28'b0, be});
            if (wr) check("avl_wdata", bus.avl_mm_writedata, wdata);
            check("busy_no_ready_no_rsp", {30'b0, bus.cmd_ready, bus.rsp_valid}, 32'd0);
            tick();
        end
        bus.avl_mm_waitrequest = 1'b0;
        bus.avl_mm_readdata    = $urandom;
        bus.avl_mm_response    = 2'($urandom);

        check("strobes_dropped", {30'b0, bus.avl_mm_read, bus.avl_mm_write}, 32'd0);
        check("rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check("rsp_resp", {30'b0, bus.rsp_resp}, {30'b0, exp_resp});
        check("rsp_timeout", {31'b0, bus.rsp_timeout}, {31'b0, to});
        check("err_count", {24'b0, bus.err_count}, 32'(err_exp));

        for (int d = 0; d < delay; d++) begin
            tick();
            check("hold_valid_no_ready", {30'b0, bus.rsp_valid, bus.cmd_ready}, 32'd2);
            check("hold_rdata", bus.rsp_rdata, exp_rdata);
            check("hold_resp", {29'b0, bus.rsp_timeout, bus.rsp_resp}, {29'b0, to, exp_resp});
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("back_to_idle", {30'b0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready_valid"}, {30'b0, bus.cmd_ready, bus.rsp_valid}, 32'd2);
        check({tag, "_rsp"}, bus.rsp_rdata | {29'b0, bus.rsp_timeout, bus.rsp_resp}, 32'd0);
        check({tag, "_err"}, {24'b0, bus.err_count}, 32'd0);
        check({tag, "_avl_ctl"}, {26'b0, bus.avl_mm_read, bus.avl_mm_write, bus.avl_mm_addr},
              32'd0);
        check({tag, "_avl_data"}, bus.avl_mm_writedata | {28'b0, bus.avl_mm_byteenable}, 32'd0);
    endtask

    logic        r_wr;
    logic [3:0]  r_be;
    logic [1:0]  r_resp;

    initial begin
        rst_n                  = 1'b0;
        bus.cmd_valid          = 1'b0;
        bus.cmd_write          = 1'b0;
        bus.cmd_addr           = '0;
        bus.cmd_wdata          = '0;
        bus.cmd_byteenable     = '0;
        bus.rsp_ready          = 1'b0;
        bus.avl_mm_readdata    = '0;
        bus.avl_mm_response    = '0;
        bus.avl_mm_waitrequest = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();

        // Zero-wait read, multi-wait write, timeout, slave error with backpressure.
        xfer(1'b0, 4'h4, 32'h0, 4'hF, 0, 32'hDEADBEEF, RespOkay, 0);
        xfer(1'b1, 4'h8, 32'h00FF00FF, 4'hF, 3, 32'h12345678, RespOkay, 0);
        xfer(1'b0, 4'h2, 32'h0, 4'hF, 20, 32'hCAFEF00D, RespOkay, 1);
        xfer(1'b0, 4'h3, 32'h0, 4'hF, 2, 32'hA5A5A5A5, RespDecodeError, 5);
        xfer(1'b1, 4'h6, 32'h11223344, 4'h0, 4, 32'h0, RespDecodeError, 2);
        xfer(1'b0, 4'h7, 32'h0, 4'h0, 1, 32'h5555AAAA, RespOkay, 0);
        xfer(1'b1, 4'h9, 32'h0BADF00D, 4'h3, 7, 32'h0, RespOkay, 0);
        xfer(1'b0, 4'hA, 32'h0, 4'hF, 8, 32'h01010101, RespOkay, 0);

        for (int i = 0; i < 40; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_be   = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
            r_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RespOkay;
            xfer(r_wr, 4'($urandom), $urandom, r_be, $urandom_range(0, 10), $urandom, r_resp,
                 $urandom_range(0, 3));
        end

        // Reset in the middle of a stalled read abandons it without a response.
        bus.avl_mm_waitrequest = 1'b1;
        bus.cmd_valid          = 1'b1;
        bus.cmd_write          = 1'b0;
        bus.cmd_byteenable     = 4'hF;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        check("stall_read_active", {31'b0, bus.avl_mm_read}, 32'd1);
        rst_n = 1'b0;
        tick();
        err_exp = 0;
        check_reset_state("mid_stall_reset");
        rst_n                  = 1'b1;
        bus.avl_mm_waitrequest = 1'b0;
        tick();
        check("post_reset_no_rsp", {30'b0, bus.rsp_valid, bus.cmd_ready}, 32'd1);

        for (int i = 0; i < 300; i++) begin
            xfer(1'b0, 4'($urandom), 32'h0, 4'hF, 0, $urandom, RespDecodeError, 0);
        end
        check("err_saturated", {24'b0, bus.err_count}, 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_mm_initiator.md
AVALON_MM_INITIATOR -- requirements
Module: avalon_mm_initiator

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_WIDTH, 4, width of the Avalon-MM address.
- TIMEOUT_CYCLES, 255, maximum stalled cycles per transfer; 0 disables the timeout.
REQ-002 The block SHALL have one clock, clk; reset is rst_n, synchronous and active-low.
REQ-003 The block SHALL have these ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  32  write data
- cmd_byteenable  in  4  byte lanes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  32  read data; 0 for writes and timeouts
- rsp_resp  out  2  Avalon response code
- rsp_timeout  out  1  transfer abandoned on timeout
- err_count  out  8  saturating error counter
- avl_mm_addr  out  ADDR_WIDTH  Avalon address
- avl_mm_read  out  1  read strobe
- avl_mm_readdata  in  32  read data, valid when read && !waitrequest
- avl_mm_response  in  2  response, valid when strobe && !waitrequest
- avl_mm_write  out  1  write strobe
- avl_mm_writedata  out  32  write data
- avl_mm_byteenable  out  4  byte lanes
- avl_mm_waitrequest  in  1  responder stall

Function
REQ-004 The FSM SHALL have four states: IDLE, READ, WRITE, RESP.
REQ-005 cmd_ready SHALL be high only in IDLE.
REQ-006 In IDLE, an accepted command SHALL be registered, with the next state READ or WRITE per cmd_write.
REQ-007 A command accepted on edge N SHALL have its strobe high in the cycle after edge N; there are no combinational paths from cmd_* to avl_mm_*.
REQ-008 In READ/WRITE, avl_mm_addr, writedata, byteenable and the strobe SHALL stay stable while waitrequest is high.
REQ-009 The transfer SHALL complete in the cycle where strobe && !waitrequest:
- capture readdata (reads only) and response;
- drop the strobe on the next edge;
- enter RESP.
REQ-010 In RESP, rsp_* SHALL be held stable and rsp_valid high until rsp_ready; then return to IDLE.
REQ-011 Back-to-back transfers SHALL therefore have a minimum spacing of 3 cycles (IDLE, strobe, RESP) at zero wait states.
REQ-012 Only one strobe SHALL be high at a time; read and write SHALL never assert together.
REQ-013 Stall counter:
- counts cycles with strobe && waitrequest;
- clears in IDLE;
- on reaching TIMEOUT_CYCLES (nonzero), drops the strobe and enters RESP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-014 If waitrequest falls in the same cycle the counter reaches the limit, normal completion SHALL win.
REQ-015 A write with cmd_byteenable=4'b0000 SHALL issue no bus cycle and go directly to RESP with rsp_resp=2'b00.
REQ-016 A read with byteenable=0 SHALL be issued normally.
REQ-017 err_count SHALL increment by 1 on each response entering RESP with rsp_timeout=1 or rsp_resp!=0, and saturate at 8'hFF; it is cleared only by reset.
REQ-018 The stall counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL never wrap.

Reset
REQ-019 On an rst_n-low edge, the block SHALL return to IDLE regardless of state; a transfer in progress is abandoned with no response.
REQ-020 After that edge the outputs SHALL be:
- cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, err_count=0;
- all avl_mm_* outputs 0.

Structure
REQ-021 The Avalon response codes (OKAY 00, RESERVED 01, SLAVEERROR 10, DECODEERROR 11) and the FSM state encodings SHALL live in the shared Avalon-MM constants package/include.
REQ-022 The block SHALL be a single flat module; the stall/timeout counter stays inline, and no sub-module is warranted.

Verification
REQ-023 Read, zero wait states: addr 4'h4, responder returns 32'hDEADBEEF/00 → strobe one cycle after accept, rsp_valid two cycles after accept, rdata DEADBEEF, resp 00.
REQ-024 Write with 3 wait states: addr 4'h8, data 32'h00FF00FF, be 4'hF → strobe held 4 cycles with stable addr/data; rsp resp 00, rdata 0.
REQ-025 Timeout with TIMEOUT_CYCLES=8: waitrequest stuck high → strobe drops after 8 stalled cycles; rsp_timeout=1, resp 10; err_count 0→1.
REQ-026 Backpressure and error: rsp_ready low for 5 cycles → rsp_* stable and cmd_ready low throughout; responder returns 11 → err_count increments; 300 errors → err_count stays FF.
REQ-027 Edge cases:
- rst_n low mid-stall → all strobes 0 and cmd_ready 1 after that edge, no rsp_valid;
- write with be=0 → no strobe at all, rsp resp 00.
